// File: rtl/s9io_axil_pkg.sv
// Shared types, response codes and byte-lane helper for the s9io AXI4-Lite register bank.
package s9io_axil_pkg;

  typedef logic [1:0]  axil_resp_t;
  typedef logic [31:0] axil_word_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  // Replace only the byte lanes whose strobe bit is set; other lanes keep the old value.
  function automatic axil_word_t byte_merge(axil_word_t old_word, axil_word_t new_word,
                                            logic [3:0] strb);
    axil_word_t merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/s9io_axil_wr_ctrl.sv
// Write-side control: captures AW and W independently, issues a single-cycle commit
// strobe once both are available, and owns the B channel. Only one write may be
// outstanding, so both readies stay low from commit until the B handshake.
module s9io_axil_wr_ctrl
  import s9io_axil_pkg::*;
#(
  parameter int IDX_W    = 2,
  parameter int NUM_REGS = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [IDX_W-1:0] aw_idx,
  input  logic             awvalid,
  output logic             awready,
  input  axil_word_t       wdata,
  input  logic [3:0]       wstrb,
  input  logic             wvalid,
  output logic             wready,
  output axil_resp_t       bresp,
  output logic             bvalid,
  input  logic             bready,
  output logic             commit,
  output logic [IDX_W-1:0] commit_idx,
  output axil_word_t       commit_data,
  output logic [3:0]       commit_strb
);

  // Register count widened by one bit so the full index range can be compared.
  localparam logic [IDX_W:0] NUM_REGS_EXT = (IDX_W+1)'(NUM_REGS);

  logic             aw_held_reg;
  logic [IDX_W-1:0] aw_idx_reg;
  logic             w_held_reg;
  axil_word_t       w_data_reg;
  logic [3:0]       w_strb_reg;
  logic             bvalid_reg;
  axil_resp_t       bresp_reg;

  logic aw_hs;
  logic w_hs;
  logic aw_avail;
  logic w_avail;
  logic idx_hit;

  // Readies derive only from local state and reset, never from the master's valids.
  assign awready = !aw_held_reg && !bvalid_reg && !srst;
  assign wready  = !w_held_reg  && !bvalid_reg && !srst;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;

  // A channel is available if it was captured earlier or is handshaking right now.
  assign aw_avail = aw_held_reg || aw_hs;
  assign w_avail  = w_held_reg  || w_hs;

  assign commit_idx  = aw_held_reg ? aw_idx_reg : aw_idx;
  assign commit_data = w_held_reg  ? w_data_reg : wdata;
  assign commit_strb = w_held_reg  ? w_strb_reg : wstrb;
  assign commit      = aw_avail && w_avail && !srst;

  assign idx_hit = {1'b0, commit_idx} < NUM_REGS_EXT;

  assign bvalid = bvalid_reg;
  assign bresp  = bresp_reg;

  // Capture AW/W, retire them on commit, and run the B handshake.
  always_ff @(posedge clk) begin
    if (srst) begin
      aw_held_reg <= 1'b0;
      aw_idx_reg  <= '0;
      w_held_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= idx_hit ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held_reg <= 1'b1;
          aw_idx_reg  <= aw_idx;
        end
        if (w_hs) begin
          w_held_reg <= 1'b1;
          w_data_reg <= wdata;
          w_strb_reg <= wstrb;
        end
        if (bvalid_reg && bready) begin
          bvalid_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/s9io_axil_regbank.sv
// AXI4-Lite responder holding NUM_REGS 32-bit control registers for the s9io datapath.
// The write channels are handled by s9io_axil_wr_ctrl; the register array and the
// read channel live here. Out-of-range indices answer SLVERR and never touch storage.
module s9io_axil_regbank
  import s9io_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_REGS*32-1:0]          reg_out,
  output logic [NUM_REGS-1:0]             reg_wr_pulse
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W:0] NUM_REGS_EXT = (IDX_W+1)'(NUM_REGS);

  logic clk;
  logic srst;
  assign clk  = s00_axi_aclk;
  assign srst = s00_axi_areset;

  // Protection bits and byte offset within a word carry no meaning for this bank.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // ---------------------------------------------------------------- write side
  logic             commit;
  logic [IDX_W-1:0] commit_idx;
  axil_word_t       commit_data;
  logic [3:0]       commit_strb;

  s9io_axil_wr_ctrl #(
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS)
  ) u_wr_ctrl (
    .clk         (clk),
    .srst        (srst),
    .aw_idx      (s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2]),
    .awvalid     (s00_axi_awvalid),
    .awready     (s00_axi_awready),
    .wdata       (s00_axi_wdata),
    .wstrb       (s00_axi_wstrb),
    .wvalid      (s00_axi_wvalid),
    .wready      (s00_axi_wready),
    .bresp       (s00_axi_bresp),
    .bvalid      (s00_axi_bvalid),
    .bready      (s00_axi_bready),
    .commit      (commit),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  // ---------------------------------------------------------------- register array
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    axil_word_t word_reg;
    logic       pulse_reg;
    logic       sel;

    assign sel = commit && (commit_idx == IDX_W'(gi));

    // One control word; the pulse marks the cycle after any commit to this index,
    // including an all-zero strobe that leaves the contents untouched.
    always_ff @(posedge clk) begin
      if (srst) begin
        word_reg  <= '0;
        pulse_reg <= 1'b0;
      end else begin
        pulse_reg <= sel;
        if (sel) begin
          word_reg <= byte_merge(word_reg, commit_data, commit_strb);
        end
      end
    end

    assign reg_out[32*gi +: 32] = word_reg;
    assign reg_wr_pulse[gi]     = pulse_reg;
  end

  // ---------------------------------------------------------------- read side
  logic [IDX_W-1:0] ar_idx;
  logic             ar_hit;
  logic             ar_hs;
  axil_word_t       rd_word;
  logic             rvalid_reg;
  axil_word_t       rdata_reg;
  axil_resp_t       rresp_reg;

  assign ar_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_hit = {1'b0, ar_idx} < NUM_REGS_EXT;

  assign s00_axi_arready = !rvalid_reg && !srst;
  assign ar_hs           = s00_axi_arvalid && s00_axi_arready;

  // Read mux over the live register contents; unmatched indices read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_word = reg_out[32*i +: 32];
      end
    end
  end

  // Register the read response and hold it until the master takes it. A write
  // committing on the same edge is not yet visible, so reads see the old value.
  always_ff @(posedge clk) begin
    if (srst) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_word;
      rresp_reg  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_reg && s00_axi_rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign s00_axi_rvalid = rvalid_reg;
  assign s00_axi_rdata  = rdata_reg;
  assign s00_axi_rresp  = rresp_reg;

endmodule

// File: tb/tb_s9io_axil_regbank.sv
// Directed bench for s9io_axil_regbank: a 4-register instance (a) and a 3-register
// instance (b) share one AXI4-Lite master; b exposes the out-of-range decode.
module tb_s9io_axil_regbank;

  logic        clk = 1'b0;
  logic        srst;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
  logic [1:0]  bresp_a, rresp_a;
  logic [31:0] rdata_a;
  logic [127:0] reg_out_a;
  logic [3:0]  pulse_a;

  logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
  logic [1:0]  bresp_b, rresp_b;
  logic [31:0] rdata_b;
  logic [95:0] reg_out_b;
  logic [2:0]  pulse_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  s9io_axil_regbank #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(4)) dut_a (
    .s00_axi_aclk(clk), .s00_axi_areset(srst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready_a), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready_a), .s00_axi_bresp(bresp_a),
    .s00_axi_bvalid(bvalid_a), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready_a),
    .s00_axi_rdata(rdata_a), .s00_axi_rresp(rresp_a), .s00_axi_rvalid(rvalid_a),
    .s00_axi_rready(rready), .reg_out(reg_out_a), .reg_wr_pulse(pulse_a)
  );

  s9io_axil_regbank #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(3)) dut_b (
    .s00_axi_aclk(clk), .s00_axi_areset(srst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready_b), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready_b), .s00_axi_bresp(bresp_b),
    .s00_axi_bvalid(bvalid_b), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready_b),
    .s00_axi_rdata(rdata_b), .s00_axi_rresp(rresp_b), .s00_axi_rvalid(rvalid_b),
    .s00_axi_rready(rready), .reg_out(reg_out_b), .reg_wr_pulse(pulse_b)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [3:0]  pulse;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write with bready high; reports responses, pulses and commit-to-bvalid latency.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp_a, output logic [1:0] resp_b,
                          output logic [3:0] pa, output logic [2:0] pb,
                          output logic [3:0] pa_after, output int lat);
    bit aw_done, w_done, seen;
    aw_done = 0; w_done = 0; seen = 0; lat = 0;
    resp_a = '1; resp_b = '1; pa = '1; pb = '1; pa_after = '1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1; bready = 1;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      if (awvalid && awready_a) aw_done = 1;
      if (wvalid && wready_a) w_done = 1;
      step();
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
    end
    if (!(aw_done && w_done)) chk("wr_handshake_timeout", 0, 1);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (bvalid_a) begin
        seen = 1;
        resp_a = bresp_a; resp_b = bresp_b; pa = pulse_a; pb = pulse_b;
      end
      step();
    end
    if (!seen) chk("wr_bvalid_timeout", 0, 1);
    @(negedge clk);
    pa_after = pulse_a;
    step();
  endtask

  // Full read with rready high; reports data/response of both instances.
  task automatic do_read(input logic [3:0] addr,
                         output logic [31:0] da, output logic [1:0] ra,
                         output logic [31:0] db, output logic [1:0] rb,
                         output logic ar_after, output int lat);
    bit done, seen;
    done = 0; seen = 0; lat = 0;
    da = '1; ra = '1; db = '1; rb = '1; ar_after = 0;
    araddr = addr; arvalid = 1; rready = 1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (arready_a) done = 1;
      step();
      if (done) arvalid = 0;
    end
    if (!done) chk("rd_handshake_timeout", 0, 1);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (rvalid_a) begin
        seen = 1;
        da = rdata_a; ra = rresp_a; db = rdata_b; rb = rresp_b;
      end
      step();
    end
    if (!seen) chk("rd_rvalid_timeout", 0, 1);
    @(negedge clk);
    ar_after = arready_a;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  ra, rb;
    logic [31:0] da, db;
    logic [3:0]  pa, pa2;
    logic [2:0]  pb;
    logic        ar_after;
    int          lat;

    // Stimulus table: writes of 1..4, read-back, then strobe and address-offset cases.
    vecs[0]  = '{1, 4'h0, 32'h00000001, 4'hF, 2'b00, 32'h0,        4'b0001};
    vecs[1]  = '{1, 4'h4, 32'h00000002, 4'hF, 2'b00, 32'h0,        4'b0010};
    vecs[2]  = '{1, 4'h8, 32'h00000003, 4'hF, 2'b00, 32'h0,        4'b0100};
    vecs[3]  = '{1, 4'hC, 32'h00000004, 4'hF, 2'b00, 32'h0,        4'b1000};
    vecs[4]  = '{0, 4'h0, 32'h0,        4'h0, 2'b00, 32'h00000001, 4'b0000};
    vecs[5]  = '{0, 4'h4, 32'h0,        4'h0, 2'b00, 32'h00000002, 4'b0000};
    vecs[6]  = '{0, 4'h8, 32'h0,        4'h0, 2'b00, 32'h00000003, 4'b0000};
    vecs[7]  = '{0, 4'hC, 32'h0,        4'h0, 2'b00, 32'h00000004, 4'b0000};
    vecs[8]  = '{0, 4'h6, 32'h0,        4'h0, 2'b00, 32'h00000002, 4'b0000};
    vecs[9]  = '{1, 4'h4, 32'h11223344, 4'hF, 2'b00, 32'h0,        4'b0010};
    vecs[10] = '{1, 4'h4, 32'hAABBCCDD, 4'h2, 2'b00, 32'h0,        4'b0010};
    vecs[11] = '{0, 4'h4, 32'h0,        4'h0, 2'b00, 32'h1122CC44, 4'b0000};
    vecs[12] = '{1, 4'h5, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0,        4'b0010};
    vecs[13] = '{0, 4'h4, 32'h0,        4'h0, 2'b00, 32'h1122CC44, 4'b0000};
    vecs[14] = '{1, 4'h1, 32'h0000A5A5, 4'h3, 2'b00, 32'h0,        4'b0001};
    vecs[15] = '{0, 4'h0, 32'h0,        4'h0, 2'b00, 32'h0000A5A5, 4'b0000};

    srst = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wdata = 0; wstrb = 0;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_awready", awready_a, 0);
    chk("rst_wready", wready_a, 0);
    chk("rst_arready", arready_a, 0);
    chk("rst_bvalid", bvalid_a, 0);
    chk("rst_rvalid", rvalid_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_reg_out", reg_out_a, 0);
    chk("rst_pulse", pulse_a, 0);
    step();
    srst = 0;
    @(negedge clk);
    chk("post_rst_awready", awready_a, 1);
    chk("post_rst_arready", arready_a, 1);
    step();

    // Table-driven transactions
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, ra, rb, pa, pb, pa2, lat);
        $display("txn %0d write addr=%0h data=%08h strb=%0h bresp=%0d pulse=%b lat=%0d",
                 i, vecs[i].addr, vecs[i].data, vecs[i].strb, ra, pa, lat);
        chk($sformatf("v%0d_bresp", i), ra, vecs[i].resp);
        chk($sformatf("v%0d_blat", i), lat, 1);
        chk($sformatf("v%0d_pulse", i), pa, vecs[i].pulse);
        chk($sformatf("v%0d_pulse_after", i), pa2, 0);
      end else begin
        do_read(vecs[i].addr, da, ra, db, rb, ar_after, lat);
        $display("txn %0d read addr=%0h rdata=%08h rresp=%0d lat=%0d",
                 i, vecs[i].addr, da, ra, lat);
        chk($sformatf("v%0d_rresp", i), ra, vecs[i].resp);
        chk($sformatf("v%0d_rdata", i), da, vecs[i].rdata);
        chk($sformatf("v%0d_rlat", i), lat, 1);
        chk($sformatf("v%0d_arready_after", i), ar_after, 1);
      end
      if (i == 8) chk("reg_out_4321", reg_out_a, {32'd4, 32'd3, 32'd2, 32'd1});
    end

    // Out-of-range index on the 3-register instance
    do_write(4'hC, 32'h00000055, 4'hF, ra, rb, pa, pb, pa2, lat);
    $display("txn oob write addr=c bresp_a=%0d bresp_b=%0d pulse_b=%b", ra, rb, pb);
    chk("oob_bresp_b", rb, 2'b10);
    chk("oob_bresp_a", ra, 2'b00);
    chk("oob_pulse_b", pb, 0);
    chk("oob_reg_out_b", reg_out_b, {32'h00000003, 32'h1122CC44, 32'h0000A5A5});
    do_read(4'hC, da, ra, db, rb, ar_after, lat);
    $display("txn oob read addr=c rdata_b=%08h rresp_b=%0d rdata_a=%08h", db, rb, da);
    chk("oob_rresp_b", rb, 2'b10);
    chk("oob_rdata_b", db, 0);
    chk("oob_rdata_a", da, 32'h00000055);

    // AW presented three cycles ahead of W
    awaddr = 4'h8; awvalid = 1; wvalid = 0; bready = 1;
    @(negedge clk);
    chk("early_aw_awready", awready_a, 1);
    step();
    awvalid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("early_aw_awready_low", awready_a, 0);
      chk("early_aw_no_bvalid", bvalid_a, 0);
      chk("early_aw_wready", wready_a, 1);
      step();
    end
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
    step();
    wvalid = 0;
    @(negedge clk);
    $display("txn early-aw write addr=8 data=deadbeef bvalid=%0d pulse=%b", bvalid_a, pulse_a);
    chk("early_aw_bvalid", bvalid_a, 1);
    chk("early_aw_bresp", bresp_a, 2'b00);
    chk("early_aw_pulse", pulse_a, 4'b0100);
    chk("early_aw_reg2", reg_out_a[95:64], 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("early_aw_b_done", bvalid_a, 0);
    step();

    // bready held low: response holds, second AW waits for the B handshake
    awaddr = 4'h4; wdata = 32'h00000077; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    chk("stall_readies", {awready_a, wready_a}, 2'b11);
    step();
    awvalid = 1; awaddr = 4'h0; wvalid = 0; wdata = 32'h00000088;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_bvalid", bvalid_a, 1);
      chk("stall_bresp", bresp_a, 2'b00);
      chk("stall_awready", awready_a, 0);
      chk("stall_wready", wready_a, 0);
      step();
    end
    bready = 1;
    step();
    @(negedge clk);
    chk("stall_b_done", bvalid_a, 0);
    chk("stall_second_awready", awready_a, 1);
    step();
    awvalid = 0;
    @(negedge clk);
    chk("stall_second_aw_held", awready_a, 0);
    step();
    wvalid = 1;
    step();
    wvalid = 0;
    @(negedge clk);
    $display("txn stall writes reg0=%08h reg1=%08h bvalid=%0d", reg_out_a[31:0], reg_out_a[63:32], bvalid_a);
    chk("stall_second_bvalid", bvalid_a, 1);
    chk("stall_reg0", reg_out_a[31:0], 32'h00000088);
    chk("stall_reg1", reg_out_a[63:32], 32'h00000077);
    step();

    // Same-cycle read and write of reg 1; rready stalls the read response
    awaddr = 4'h4; araddr = 4'h4; wdata = 32'h12345678; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 0;
    @(negedge clk);
    chk("rw_readies", {awready_a, wready_a, arready_a}, 3'b111);
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    $display("txn rw same-index rdata=%08h reg1=%08h", rdata_a, reg_out_a[63:32]);
    chk("rw_rdata_old", rdata_a, 32'h00000077);
    chk("rw_reg1_new", reg_out_a[63:32], 32'h12345678);
    chk("rw_bvalid", bvalid_a, 1);
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      chk("rw_rvalid_hold", rvalid_a, 1);
      chk("rw_rdata_hold", rdata_a, 32'h00000077);
      chk("rw_arready_low", arready_a, 0);
    end
    step();
    rready = 1;
    step();
    @(negedge clk);
    chk("rw_r_done", rvalid_a, 0);
    chk("rw_arready_again", arready_a, 1);
    step();

    // Reset between AW and W handshakes
    awaddr = 4'h0; awvalid = 1; wvalid = 0;
    @(negedge clk);
    chk("mid_rst_awready", awready_a, 1);
    step();
    awvalid = 0; srst = 1;
    @(negedge clk);
    chk("mid_rst_readies", {awready_a, wready_a, arready_a}, 3'b000);
    step();
    srst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_no_bvalid", bvalid_a, 0);
      chk("mid_rst_regs", reg_out_a, 0);
      chk("mid_rst_readies_back", {awready_a, wready_a}, 2'b11);
      step();
    end
    do_write(4'h0, 32'h00000099, 4'hF, ra, rb, pa, pb, pa2, lat);
    $display("txn post-reset write addr=0 bresp=%0d pulse=%b lat=%0d", ra, pa, lat);
    chk("post_rst_bresp", ra, 2'b00);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_regs", reg_out_a, {96'h0, 32'h00000099});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
